// File: rtl/top_level_module_pkg.sv
// Shared definitions for the SPI man-in-the-middle bridge: mode encodings,
// frame geometry and opcode constants.
package top_level_module_pkg;

  typedef enum logic [1:0] {
    MODE_FORWARD  = 2'd0,
    MODE_SUB_ALL  = 2'd1,
    MODE_SUB_READ = 2'd2,
    MODE_BLOCK    = 2'd3
  } mode_e;

  localparam int unsigned FRAME_SIZE = 20;
  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned CNT_W      = 5;

  localparam logic [2:0] OP_READ  = 3'b110;
  localparam logic [2:0] OP_WRITE = 3'b101;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_FORWARD:  return MODE_SUB_ALL;
      MODE_SUB_ALL:  return MODE_SUB_READ;
      MODE_SUB_READ: return MODE_BLOCK;
      default:       return MODE_FORWARD;
    endcase
  endfunction

endpackage

// File: rtl/top_level_module_button_debouncer.sv
// Push-button debouncer: 2-FF synchronizer plus a stability counter; a new
// level is accepted only after it has persisted DEBOUNCE_COUNT cycles.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_COUNT = 120000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_COUNT + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    // Any return to the accepted level restarts the stability count.
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_COUNT - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/top_level_module.sv
// SPI bridge: re-drives the four SPI lines with a fixed 3-cycle latency and
// optionally substitutes the data byte of 20-bit frames per the active mode.
module top_level_module
  import top_level_module_pkg::*;
#(
  parameter int unsigned           DEBOUNCE_COUNT = 120000,
  parameter logic [DATA_WIDTH-1:0] SUB_DATA       = 8'h5A
) (
  input  logic       ref_clk,
  input  logic       rst_btn,
  input  logic       mode_btn,
  input  logic       miso_in,
  input  logic       mosi_in,
  input  logic       sclk_in,
  input  logic       ss_in,
  output logic [1:0] mode_leds,
  output logic       comm_active_led,
  output logic       miso_out,
  output logic       mosi_out,
  output logic       sclk_out,
  output logic       ss_out
);

  localparam int unsigned       IDX_W      = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  FRAME_END  = CNT_W'(FRAME_SIZE);
  localparam logic [CNT_W-1:0]  FRAME_LAST = CNT_W'(FRAME_SIZE - 1);
  localparam logic [CNT_W-1:0]  SUB_START  = CNT_W'(FRAME_SIZE - DATA_WIDTH);
  localparam logic [CNT_W-1:0]  OP_BITS    = CNT_W'(3);

  logic [3:0]       meta_q, sync_q;
  logic             miso_s, mosi_s, sclk_s, ss_s;
  logic             sclk_prev_q;
  logic [1:0]       warm_q;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       opcode_q, opcode_d;
  mode_e            mode_q, mode_d;
  logic             pending_q, pending_d;
  logic             btn_level, btn_prev_q;
  logic [3:0]       out_q, out_d;

  logic             sclk_rise, ss_low, press, sub_pos, sub_bit;
  logic [IDX_W-1:0] sub_idx;

  button_debouncer #(
    .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
  ) u_debounce (
    .clk_i  (ref_clk),
    .rst_i  (rst_btn),
    .btn_i  (mode_btn),
    .level_o(btn_level)
  );

  assign {miso_s, mosi_s, sclk_s, ss_s} = sync_q;

  always_comb begin
    sclk_rise = sclk_s & ~sclk_prev_q;
    // Synchronizer contents are only trusted once reset zeros have flushed out.
    ss_low    = ~ss_s & warm_q[1];
    press     = btn_prev_q & ~btn_level;

    armed_d  = armed_q | ss_low;
    cnt_d    = cnt_q;
    opcode_d = opcode_q;
    if (!ss_s) begin
      cnt_d    = '0;
      opcode_d = '0;
    end else if (sclk_rise && (cnt_q < FRAME_END)) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q < OP_BITS) opcode_d = {opcode_q[1:0], mosi_s};
    end

    mode_d    = mode_q;
    pending_d = pending_q;
    if ((pending_q || press) && ss_low) begin
      mode_d    = next_mode(mode_q);
      pending_d = 1'b0;
    end else if (press) begin
      pending_d = 1'b1;
    end

    sub_pos = armed_q && (cnt_q >= SUB_START) && (cnt_q < FRAME_END);
    sub_idx = IDX_W'(FRAME_LAST - cnt_q);
    sub_bit = SUB_DATA[sub_idx];

    out_d = {miso_s, mosi_s, sclk_s, ss_s};
    if (sub_pos) begin
      case (mode_q)
        MODE_SUB_ALL: begin
          out_d[3] = sub_bit;
          out_d[2] = sub_bit;
        end
        MODE_SUB_READ: if (opcode_q == OP_READ) out_d[3] = sub_bit;
        default: ;
      endcase
    end
    if (mode_q == MODE_BLOCK) out_d[0] = 1'b0;
  end

  always_ff @(posedge ref_clk) begin
    if (rst_btn) begin
      meta_q      <= '0;
      sync_q      <= '0;
      sclk_prev_q <= 1'b0;
      warm_q      <= '0;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      opcode_q    <= '0;
      mode_q      <= MODE_FORWARD;
      pending_q   <= 1'b0;
      btn_prev_q  <= 1'b1;
      out_q       <= '0;
    end else begin
      meta_q      <= {miso_in, mosi_in, sclk_in, ss_in};
      sync_q      <= meta_q;
      sclk_prev_q <= sclk_s;
      warm_q      <= {warm_q[0], 1'b1};
      armed_q     <= armed_d;
      cnt_q       <= cnt_d;
      opcode_q    <= opcode_d;
      mode_q      <= mode_d;
      pending_q   <= pending_d;
      btn_prev_q  <= btn_level;
      out_q       <= out_d;
    end
  end

  assign {miso_out, mosi_out, sclk_out, ss_out} = out_q;
  assign mode_leds       = mode_q;
  assign comm_active_led = ss_s;

endmodule

// File: tb/tb_top_level_module.sv
// Directed bench for the SPI bridge: frame-level model of ideal outputs,
// delayed and compared every cycle, plus literal byte-capture checks.
module tb_top_level_module;

  localparam int unsigned DEB = 16;
  localparam logic [7:0]  SUB = 8'h5A;

  logic       ref_clk  = 1'b0;
  logic       rst_btn  = 1'b1;
  logic       mode_btn = 1'b1;
  logic       miso_in  = 1'b0;
  logic       mosi_in  = 1'b0;
  logic       sclk_in  = 1'b0;
  logic       ss_in    = 1'b0;
  logic [1:0] mode_leds;
  logic       comm_active_led, miso_out, mosi_out, sclk_out, ss_out;

  top_level_module #(
    .DEBOUNCE_COUNT(DEB),
    .SUB_DATA      (SUB)
  ) dut (
    .ref_clk        (ref_clk),
    .rst_btn        (rst_btn),
    .mode_btn       (mode_btn),
    .miso_in        (miso_in),
    .mosi_in        (mosi_in),
    .sclk_in        (sclk_in),
    .ss_in          (ss_in),
    .mode_leds      (mode_leds),
    .comm_active_led(comm_active_led),
    .miso_out       (miso_out),
    .mosi_out       (mosi_out),
    .sclk_out       (sclk_out),
    .ss_out         (ss_out)
  );

  always #5 ref_clk = ~ref_clk;

  typedef struct {
    logic ss, sclk, mosi, miso, ss_o, chk, rst;
  } rec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_chg   = 0;
  int          model_mode = 0;
  logic        i_mosi = 1'b0, i_miso = 1'b0, i_chk = 1'b1;
  rec_t        hist [64];
  int unsigned ecnt = 0;
  rec_t        r1, r2, r3;
  logic [1:0]  prev_mode = 2'd0;
  logic        prev_sclk = 1'b0;
  logic [19:0] cap_mosi = '0, cap_miso = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Ideal outputs are recorded when the inputs are sampled and expected 3 edges later.
  always @(posedge ref_clk) begin
    hist[ecnt % 64] = '{ss: ss_in, sclk: sclk_in, mosi: i_mosi, miso: i_miso,
                        ss_o: (model_mode == 3) ? 1'b0 : ss_in, chk: i_chk, rst: rst_btn};
    ecnt++;
    #1;
    if (ecnt >= 4) begin
      r1 = hist[(ecnt - 1) % 64];
      r2 = hist[(ecnt - 2) % 64];
      r3 = hist[(ecnt - 3) % 64];
      if (r1.rst || r2.rst || r3.rst) begin
        check("out_reset", {miso_out, mosi_out, sclk_out, ss_out}, 0);
      end else begin
        check("sclk_out", sclk_out, r3.sclk);
        check("ss_out", ss_out, r3.ss_o);
        if (r3.chk) begin
          check("mosi_out", mosi_out, r3.mosi);
          check("miso_out", miso_out, r3.miso);
        end
      end
      check("comm_led", comm_active_led, (r1.rst || r2.rst) ? 1'b0 : r2.ss);
      if (r1.rst) begin
        check("mode_reset", mode_leds, 0);
      end else if (mode_leds != prev_mode) begin
        n_chg++;
        check("mode_step", mode_leds, 2'(prev_mode + 2'd1));
        check("mode_when_ss_low", r3.ss, 0);
      end
      prev_mode = mode_leds;
      if (!comm_active_led) begin
        cap_mosi = '0;
        cap_miso = '0;
      end else if (sclk_out && !prev_sclk) begin
        cap_mosi = {cap_mosi[18:0], mosi_out};
        cap_miso = {cap_miso[18:0], miso_out};
      end
      prev_sclk = sclk_out;
    end
  end

  task automatic step(input logic ss, sclk, mosi, miso, im, is, chk);
    @(negedge ref_clk);
    ss_in = ss; sclk_in = sclk; mosi_in = mosi; miso_in = miso;
    i_mosi = im; i_miso = is; i_chk = chk;
  endtask

  task automatic run_frame(input string nm, input logic [19:0] mw, sw, emw, esw, input int rst_bit);
    logic       armed = 1'b1;
    logic [7:0] subv  = SUB;
    logic       bm, bs, sb, sub, im, is;
    repeat (4) step(1, 0, 0, 0, 0, 0, 1);
    for (int p = 0; p < 20; p++) begin
      bm = mw[19-p];
      bs = sw[19-p];
      sb = (p >= 12) ? subv[19-p] : 1'b0;
      for (int c = 0; c < 8; c++) begin
        if (p == rst_bit && c == 0) begin
          model_mode = 0;
          armed = 1'b0;
        end
        sub = armed && (p >= 12);
        im  = (sub && model_mode == 1) ? sb : bm;
        is  = (sub && (model_mode == 1 || (model_mode == 2 && mw[19:17] == 3'b110))) ? sb : bs;
        // Data is only meaningful up to and including the cycle of its clock rise.
        step(1, c >= 4, bm, bs, im, is, c <= 4);
        if (p == rst_bit && c == 0) begin
          rst_btn = 1'b1;
        end else if (p == rst_bit && c == 1) begin
          rst_btn = 1'b0;
          check("rst_mode_next", mode_leds, 0);
          check("rst_outs_next", {miso_out, mosi_out, sclk_out, ss_out}, 0);
        end
      end
    end
    repeat (4) step(1, 0, 0, 0, 0, 0, 1);
    if (rst_bit < 0) begin
      check({nm, "_mosi"}, cap_mosi, emw);
      check({nm, "_miso"}, cap_miso, esw);
    end
    repeat (8) step(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic wait_mode(input string nm, input int exp);
    for (int i = 0; i < 200; i++) begin
      @(negedge ref_clk);
      if (mode_leds == 2'(exp)) break;
    end
    check(nm, mode_leds, exp);
    model_mode = exp;
  endtask

  task automatic press_btn();
    mode_btn = 1'b0;
    repeat (30) @(negedge ref_clk);
    mode_btn = 1'b1;
    repeat (30) @(negedge ref_clk);
  endtask

  task automatic bounce(input int n);
    for (int i = 0; i < n; i++) begin
      #($urandom_range(0, 99));
      mode_btn = ~mode_btn;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (4) @(negedge ref_clk);
    check("reset_mode", mode_leds, 0);
    check("reset_outs", {comm_active_led, miso_out, mosi_out, sclk_out, ss_out}, 0);
    rst_btn = 1'b0;
    repeat (6) step(0, 0, 0, 0, 0, 0, 1);

    run_frame("m0_read", 20'hC9A00, 20'h000A3, 20'hC9A00, 20'h000A3, -1);

    step(1, 0, 0, 0, 0, 0, 1);
    bounce(40);
    mode_btn = 1'b0;
    repeat (40) @(negedge ref_clk);
    check("noisy_hold_ss_high", mode_leds, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    wait_mode("noisy_press", 1);
    bounce(40);
    mode_btn = 1'b1;
    repeat (40) @(negedge ref_clk);
    check("release_bounce_mode", mode_leds, 1);
    check("release_bounce_chg", n_chg, 1);

    run_frame("m1_read", 20'hC9A00, 20'h000B5, 20'hC9A5A, 20'h0005A, -1);
    run_frame("m1_write", 20'hA376D, 20'h00000, 20'hA375A, 20'h0005A, -1);

    fork
      run_frame("m1_midpress", 20'hC9A00, 20'h000B5, 20'hC9A5A, 20'h0005A, -1);
      begin
        repeat (60) @(negedge ref_clk);
        mode_btn = 1'b0;
        repeat (30) @(negedge ref_clk);
        check("midpress_still_m1", mode_leds, 1);
        mode_btn = 1'b1;
      end
    join
    wait_mode("midpress_after", 2);

    run_frame("m2_read", 20'hC9A00, 20'h000A3, 20'hC9A00, 20'h0005A, -1);
    run_frame("m2_write", 20'hA376D, 20'h00011, 20'hA376D, 20'h00011, -1);

    press_btn();
    wait_mode("to_block", 3);
    run_frame("m3_block", 20'hC9A00, 20'h000A3, 20'hC9A00, 20'h000A3, -1);

    press_btn();
    wait_mode("wrap_to_0", 0);
    run_frame("m0_write", 20'hA376D, 20'h00011, 20'hA376D, 20'h00011, -1);

    press_btn();
    wait_mode("before_rst", 1);
    run_frame("rst_frame", 20'hA376D, 20'h000B5, 20'h0, 20'h0, 10);
    run_frame("after_rst", 20'hA376D, 20'h000B5, 20'hA376D, 20'h000B5, -1);
    check("mode_changes", n_chg, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/top_level_module.md
# top_level_module

SPI man-in-the-middle bridge for a single upstream master and downstream slave, for FPGA use. It re-drives the four SPI lines (MISO, MOSI, SCLK, SS) from input pins to output pins. It can substitute the data byte of 20-bit frames according to a mode selected by a debounced push button. Mode and bus activity are shown on LEDs.

## Interface
- DEBOUNCE_COUNT, 120000: consecutive stable clock cycles required to accept a new mode_btn level.
- SUB_DATA, 8'h5A: byte substituted into data fields.
- ref_clk  in  1  system clock; SPI rate must be ≥8× slower.
- rst_btn  in  1  reset; synchronous, active-high; one clock domain (ref_clk).
- mode_btn  in  1  raw push button, active-low (idle 1), bouncy.
- miso_in, mosi_in, sclk_in, ss_in  in  1 each  asynchronous SPI inputs; SS active-high, data sampled on SCLK rise, MSB first.
- mode_leds  out  2  current mode.
- comm_active_led  out  1  synchronized ss_in.
- miso_out, mosi_out, sclk_out, ss_out  out  1 each  re-driven SPI lines.

## Operation
- The frame is 20 bits: opcode[19:17], address[16:8], data[7:0]. Opcode READ is 3'b110 (slave returns data on MISO bits 7..0). Opcode WRITE is 3'b101.
- Every SPI input passes through a 2-FF synchronizer, then a single output register.
- Bit counter:
  - Cleared while synchronized SS is low.
  - Increments on each synchronized SCLK rising edge, saturating at 20.
  - Frame position p is the count value before the p-th rise.
- Opcode register captures the synchronized MOSI at positions 0..2.
- Modes (2 bits), with substitution applied only at positions 12..19 (output bit = SUB_DATA[19-p]):
  - 0 FORWARD: all outputs equal the delayed inputs.
  - 1 SUB_ALL: substitute on both miso_out and mosi_out in every frame.
  - 2 SUB_READ: substitute on miso_out only, in frames whose captured opcode is READ.
  - 3 BLOCK: ss_out forced 0; other lines forwarded.
- A mode button press advances the mode 0→1→2→3→0.
- A press is a falling edge of the debounced button. The debouncer accepts a new synchronized level only after it has been stable for DEBOUNCE_COUNT consecutive cycles; shorter bounces are ignored.
- A press is held as pending. The mode updates only while synchronized SS is low, so a press made mid-frame applies after the frame ends.
- A second press while one is pending is dropped.
- mode_leds shows the active mode, not the pending one.
- Positions ≥20: always forwarded.
- A frame aborted early (SS falls) clears the counter and opcode register.

## Timing
- Input-to-output latency is 3 ref_clk cycles, identical on all four lines, so phase relationships are preserved.
- The count update and the output register share a cycle. The substituted bit for position p is therefore stable on mosi_out/miso_out before and at the p-th sclk_out rise.
- Reset (rst_btn high at a ref_clk edge) sets:
  - mode to 0, pending press cleared;
  - counter and opcode register to 0;
  - debouncer state to released (1) and its counter to 0;
  - all outputs to 0.
- Reset asserted mid-frame drops the frame. Forwarding resumes 3 cycles after release. Substitution restarts only at the next SS rise.
- Mode change takes effect on the first cycle with synchronized SS low after the debounced press edge.

## Structure
- Shared package:
  - mode encodings FORWARD/SUB_ALL/SUB_READ/BLOCK;
  - FRAME_SIZE=20, DATA_WIDTH=8;
  - opcode constants READ=3'b110, WRITE=3'b101.
- Sub-module button_debouncer (parameter DEBOUNCE_COUNT): synchronizer, stable counter, debounced level output.
- The rest is the top: synchronizers, SPI position tracker, mode FSM, output mux.

## Test plan
- Mode 0, READ frame: MOSI {110, 9'h09A, 8'h00} and MISO {000, 9'h000, 8'hA3} → outputs bit-identical to inputs, delayed 3 cycles; comm_active_led follows ss_in.
- Noisy mode_btn:
  - 40 random toggles of 0–99 ns (each shorter than DEBOUNCE_COUNT cycles), then held low 16+ cycles → mode_leds goes 0→1 exactly once, after SS is low.
  - Release bounces → no further change.
- Mode 1: MISO byte 8'hB5 → miso_out byte 8'h5A. WRITE frame {101, 9'h037, 8'h6D} → mosi_out byte 8'h5A; opcode and address unchanged.
- Mode 2:
  - READ with MISO 8'hA3 → 8'h5A.
  - WRITE with MOSI 8'h6D → 8'h6D forwarded.
- Press mid-frame in mode 1 → whole frame still substituted; mode_leds=2 only after ss_in falls. Next press → mode 3: ss_out stays 0 while ss_in=1. Next press → mode 0 (wrap).
- rst_btn high during bit 10 of a frame → all outputs 0, mode 0 next cycle; following frame forwarded unmodified.
